mux_n_pipe: RTL and testbench
=============================

# mux_n_pipe

Parametrised N-way, WIDTH-bit registered selector with a valid/ready handshake on both sides and a one-entry skid buffer, so the selected word flows at one transfer per cycle with no combinational path from `out_ready` to `in_ready`. It replaces the fixed two- and three-input combinational selectors wherever a selected operand, PC or writeback value crosses a pipeline stage boundary. It also supports a programmable reset value, such as the PC start address.

## Interface
- `WIDTH`, 32, data width of each lane and of the output.
- `N`, 3, number of input lanes; legal range 2..16.
- `RESET_VAL`, 32'h10008, value of `out_data` after reset; truncated to WIDTH.
- `SEL_W` is a localparam, not overridable: `$clog2(N)`.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  N*WIDTH  flattened lanes; lane k is at `[k*WIDTH +: WIDTH]`.
- `in_sel`  in  SEL_W  lane index.
- `in_valid`  in  1  source offers `in_data`/`in_sel`.
- `in_ready`  out  1  block can accept; equals `!skid_valid`, driven from a flop.
- `out_data`  out  WIDTH  selected word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink consumes.
- `err`  out  1  sticky illegal-select flag; present only with `MUX_N_PIPE_ERR_EN`.
- `err_sel`  out  SEL_W  index of the first illegal select; present only with `MUX_N_PIPE_ERR_EN`.
- `err_clr`  in  1  clears `err` and `err_sel`; present only with `MUX_N_PIPE_ERR_EN`.

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Pop: `out_valid && out_ready`.
- Storage: main register (`out_data`, `out_valid`) plus skid register (`skid_data`, `skid_valid`).
- Output state, derived from the two valid bits:
  - EMPTY (0,0): accept loads main.
  - ONE (1,0):
    - Accept and pop together: main is loaded with the new word.
    - Accept without pop: the new word goes to skid, giving FULL.
    - Pop only: EMPTY.
  - FULL (1,1): `in_ready` is 0. Pop moves skid to main, giving ONE.
- Order is always preserved. No word is dropped or duplicated under any `out_ready` pattern.
- An illegal select is `in_sel >= N`, possible only when N is not a power of two. With `MUX_N_PIPE_ERR_EN` off, it forwards lane 0.
- Data is captured at the accepting edge. Later changes to `in_data` have no effect on stored words.
- `out_data` holds its last value when `out_valid` is 0. It is never zeroed.

## Timing
- Reset values:
  - `out_data` = RESET_VAL.
  - `out_valid` = 0.
  - `skid_valid` = 0, so `in_ready` = 1.
  - `err` = 0 and `err_sel` = 0.
- Latency: an accept at edge t gives `out_valid` = 1 after edge t, with `out_data` equal to the selected lane.
- Throughput: 1 word per cycle while `out_ready` = 1.
- After a stall releases, `in_ready` rises one cycle after the first pop from FULL.
- Reset asserted mid-operation empties both registers immediately (asynchronously). Words in flight are lost. `out_data` returns to RESET_VAL.
- `err_clr` together with a new illegal accept in the same cycle: the set wins, and `err_sel` takes the new index.

## Configuration
- `MUX_N_PIPE_ERR_EN` defined:
  - An accept with an illegal select is consumed but not forwarded. No output transfer occurs.
  - `err` is set.
  - `err_sel` captures the index, but only if `err` was 0.
  - Under simulation, `$display` reports the event.
- `MUX_N_PIPE_ERR_EN` undefined:
  - The `err`, `err_sel` and `err_clr` ports and their logic are absent.
  - An illegal select forwards lane 0.

## Structure
- Shared package `mux_pkg`:
  - `MUX_PC_RESET_VAL` = 32'h10008.
  - `MUX_DEFAULT_WIDTH` = 32.
  - `MUX_MAX_N` = 16.
- One sub-module, `mux_n_sel`: a combinational N:1 lane selector that outputs the selected word and an `illegal` flag. The handshake and skid logic stay in `mux_n_pipe`.

## Test plan
- Reset with N=3 and WIDTH=32 → `out_data` = 32'h10008, `out_valid` = 0, `in_ready` = 1.
- Lanes = {0x33, 0x22, 0x11}, stream `in_sel` = 0, 1, 2 with `out_ready` = 1 → `out_data` = 0x11, 0x22, 0x33 on 3 consecutive cycles, each 1 cycle after its accept.
- Hold `out_ready` = 0 and offer 3 words → 2 words are accepted, `in_ready` = 0 from the cycle after the second accept, the third is held off. Release `out_ready` → all 3 words appear in order, with no gaps after the first.
- Random `in_valid`/`out_ready` for 10k cycles against a scoreboard → zero loss, duplication or reorder.
- With `MUX_N_PIPE_ERR_EN`, send `in_sel` = 3 at N=3 → no output transfer, `err` = 1, `err_sel` = 3. A second illegal select leaves `err_sel` unchanged. Pulse `err_clr` → `err` = 0.
- Assert `reset` in FULL state → `out_valid` and `in_ready` recover immediately to 0 and 1, and `out_data` = RESET_VAL.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the registered lane selectors.
package mux_pkg;

  localparam logic [31:0]  MUX_PC_RESET_VAL  = 32'h10008;
  localparam int unsigned  MUX_DEFAULT_WIDTH = 32;
  localparam int unsigned  MUX_MAX_N         = 16;

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N:1 lane selector; out-of-range selects return lane 0 and raise illegal_c.
module mux_n_sel
  import mux_pkg::*;
#(
  parameter int unsigned  WIDTH = MUX_DEFAULT_WIDTH,
  parameter int unsigned  N     = 3,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] lanes,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   data_c,
  output logic               illegal_c
);

  // Lane 0 is the fallback, so an illegal index never produces X.
  always_comb begin
    data_c    = lanes[WIDTH-1:0];
    illegal_c = 32'(sel) >= N;
    for (int unsigned k = 1; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        data_c = lanes[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way registered selector with valid/ready on both sides and a one-entry skid
// buffer. in_ready comes straight from a flop, so out_ready never reaches it
// combinationally. Optional macro MUX_N_PIPE_ERR_EN adds the sticky
// illegal-select flag (err/err_sel/err_clr) and drops illegal words.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int unsigned  WIDTH     = MUX_DEFAULT_WIDTH,
  parameter int unsigned  N         = 3,
  parameter logic [31:0]  RESET_VAL = MUX_PC_RESET_VAL,
  localparam int unsigned SEL_W     = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_N_PIPE_ERR_EN
  ,
  output logic               err,
  output logic [SEL_W-1:0]   err_sel,
  input  logic               err_clr
`endif
);

  localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] sel_data;
  logic             sel_illegal;
  logic [WIDTH-1:0] skid_data, skid_data_n, out_data_n;
  logic             skid_valid, skid_valid_n, out_valid_n, in_ready_n;
  logic             accept, pop, fwd;

  mux_n_sel #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_sel (
    .lanes     (in_data),
    .sel       (in_sel),
    .data_c    (sel_data),
    .illegal_c (sel_illegal)
  );

  // Handshake decode; with the error option an illegal word is consumed but not forwarded.
  always_comb begin
    accept = in_valid && in_ready;
    pop    = out_valid && out_ready;
`ifdef MUX_N_PIPE_ERR_EN
    fwd    = accept && !sel_illegal;
`else
    fwd    = accept;
`endif
  end

`ifndef MUX_N_PIPE_ERR_EN
  // Illegal selects simply forward lane 0 here, so the flag has no consumer.
  logic unused_sel_illegal;
  assign unused_sel_illegal = sel_illegal;
`endif

  // Main/skid next state: EMPTY -> ONE -> FULL, skid drains into main on pop.
  always_comb begin
    out_data_n   = out_data;
    out_valid_n  = out_valid;
    skid_data_n  = skid_data;
    skid_valid_n = skid_valid;
    if (skid_valid) begin
      if (pop) begin
        out_data_n   = skid_data;
        skid_valid_n = 1'b0;
      end
    end else if (fwd) begin
      if (!out_valid || pop) begin
        out_data_n  = sel_data;
        out_valid_n = 1'b1;
      end else begin
        skid_data_n  = sel_data;
        skid_valid_n = 1'b1;
      end
    end else if (pop) begin
      out_valid_n = 1'b0;
    end
    in_ready_n = !skid_valid_n;
  end

  // Datapath and handshake registers; out_data holds its value while invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= RST_DATA;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      skid_data  <= skid_data_n;
      skid_valid <= skid_valid_n;
      in_ready   <= in_ready_n;
    end
  end

`ifdef MUX_N_PIPE_ERR_EN
  logic             err_n;
  logic [SEL_W-1:0] err_sel_n;

  // Sticky flag: first illegal index is kept; a simultaneous clear loses to a new set.
  always_comb begin
    err_n     = err;
    err_sel_n = err_sel;
    if (accept && sel_illegal) begin
      err_n = 1'b1;
      if (!err || err_clr) begin
        err_sel_n = in_sel;
      end
    end else if (err_clr) begin
      err_n     = 1'b0;
      err_sel_n = '0;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err     <= 1'b0;
      err_sel <= '0;
    end else begin
      err     <= err_n;
      err_sel <= err_sel_n;
    end
  end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench for mux_n_pipe (N=3, WIDTH=32). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_mux_n_pipe;

  localparam int unsigned N     = 3;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned SEL_W = $clog2(N);
  localparam logic [31:0] RST_V = 32'h10008;

  logic               clk = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_N_PIPE_ERR_EN
  logic               err;
  logic [SEL_W-1:0]   err_sel;
  logic               err_clr;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(
    .WIDTH     (WIDTH),
    .N         (N),
    .RESET_VAL (RST_V)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_N_PIPE_ERR_EN
    ,
    .err       (err),
    .err_sel   (err_sel),
    .err_clr   (err_clr)
`endif
  );

  // Reference model: lane k of a flattened bus, and whether a select is forwarded.
  function automatic logic [WIDTH-1:0] lane_of(input logic [N*WIDTH-1:0] d, input int k);
    return d[k*WIDTH +: WIDTH];
  endfunction

  function automatic bit forwards(input int sel);
`ifdef MUX_N_PIPE_ERR_EN
    return sel < int'(N);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] expected_word(input logic [N*WIDTH-1:0] d, input int sel);
    return (sel < int'(N)) ? lane_of(d, sel) : lane_of(d, 0);
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sel = '0; in_data = '0;
`ifdef MUX_N_PIPE_ERR_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_data !== RST_V) begin fails++; $display("FAIL reset_out_data: got %h expected %h", out_data, RST_V); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef MUX_N_PIPE_ERR_EN
    checks++; if (err !== 1'b0 || err_sel !== '0) begin fails++; $display("FAIL reset_err: got err=%b sel=%0d expected 0/0", err, err_sel); end
`endif
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] exp_w [3];
    exp_w = '{32'h11, 32'h22, 32'h33};
    in_data = {32'h33, 32'h22, 32'h11};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_sel = SEL_W'(i); in_valid = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
        fails++; $display("FAIL stream_word%0d: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, exp_w[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drained: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_data = {32'h33, 32'h22, 32'h11};
    in_valid = 1'b1; in_sel = SEL_W'(2);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL stall_first: got ready=%b valid=%b expected 1/1", in_ready, out_valid); end
    in_sel = SEL_W'(0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_full_ready: got %b expected 0", in_ready); end
    // Third word offered; stored words must not follow later in_data changes.
    in_sel = SEL_W'(1);
    in_data = {32'hDEAD0002, 32'h22, 32'hDEAD0000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h33) begin
        fails++; $display("FAIL stall_hold%0d: got ready=%b valid=%b data=%h expected 0/1/33", i, in_ready, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h11 || in_ready !== 1'b1) begin
      fails++; $display("FAIL stall_release1: got valid=%b data=%h ready=%b expected 1/11/1", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h22) begin
      fails++; $display("FAIL stall_release2: got valid=%b data=%h expected 1/22", out_valid, out_data);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_drained: got valid=%b expected 0", out_valid); end
  endtask

`ifdef MUX_N_PIPE_ERR_EN
  task automatic test_err();
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = SEL_W'(3);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || err !== 1'b1 || err_sel !== SEL_W'(3)) begin
      fails++; $display("FAIL err_first: got valid=%b err=%b sel=%0d expected 0/1/3", out_valid, err, err_sel);
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || err !== 1'b1 || err_sel !== SEL_W'(3)) begin
      fails++; $display("FAIL err_second: got valid=%b err=%b sel=%0d expected 0/1/3", out_valid, err, err_sel);
    end
    in_valid = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (err !== 1'b1 || err_sel !== SEL_W'(3)) begin
      fails++; $display("FAIL err_set_wins: got err=%b sel=%0d expected 1/3", err, err_sel);
    end
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0 || err_sel !== '0) begin
      fails++; $display("FAIL err_clear: got err=%b sel=%0d expected 0/0", err, err_sel);
    end
  endtask
`endif

  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_w;
    int               sel;
    for (int cyc = 0; cyc < 10004; cyc++) begin
      if (cyc < 10000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        sel       = int'($urandom_range(0, 3));
        in_sel    = SEL_W'(sel);
        in_data   = {$urandom, $urandom, $urandom};
        out_ready = ((cyc / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      end else begin
        in_valid = 1'b0; sel = 0; in_sel = '0; out_ready = 1'b1;
      end
      checks++; if (in_ready !== (q.size() < 2)) begin
        fails++; $display("FAIL rand_in_ready cyc=%0d: got %b expected %b", cyc, in_ready, q.size() < 2);
      end
      checks++; if (out_valid !== (q.size() > 0)) begin
        fails++; $display("FAIL rand_out_valid cyc=%0d: got %b expected %b", cyc, out_valid, q.size() > 0);
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand_extra_word cyc=%0d: got %h expected none", cyc, out_data);
        end else begin
          exp_w = q.pop_front();
          if (out_data !== exp_w) begin
            fails++; $display("FAIL rand_data cyc=%0d: got %h expected %h", cyc, out_data, exp_w);
          end
        end
      end
      if (in_valid && in_ready === 1'b1 && forwards(sel)) q.push_back(expected_word(in_data, sel));
      @(negedge clk);
    end
    checks++; if (q.size() != 0) begin fails++; $display("FAIL rand_lost: got %0d words undelivered expected 0", q.size()); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_data = {32'hC3, 32'hB2, 32'hA1};
    in_valid = 1'b1; in_sel = SEL_W'(0);
    @(negedge clk);
    in_sel = SEL_W'(1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL full_before_reset: got ready=%b valid=%b expected 0/1", in_ready, out_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RST_V) begin
      fails++; $display("FAIL async_reset: got valid=%b ready=%b data=%h expected 0/1/%h", out_valid, in_ready, out_data, RST_V);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== RST_V) begin
      fails++; $display("FAIL after_reset: got valid=%b data=%h expected 0/%h", out_valid, out_data, RST_V);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
`ifdef MUX_N_PIPE_ERR_EN
    test_err();
`endif
    test_random();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
